// File: rtl/h14tx_tmds_channel.sv
// One TMDS channel encoder: 8b/10b video data with DC balancing, control and guard-band symbols.
// Latency 2 clk (3 clk with H14TX_TMDS_OUT_REG_EN); one symbol per clk, no backpressure.
module h14tx_tmds_channel #(
  parameter int ChannelIndex = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] period,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds
);

  // period_t encoding shared with h14tx_timings_top; codes 4..7 are data-island periods.
  localparam logic [2:0] PeriodControl       = 3'd0;
  localparam logic [2:0] PeriodVideoPreamble = 3'd1;
  localparam logic [2:0] PeriodVideoGuard    = 3'd2;
  localparam logic [2:0] PeriodVideoData     = 3'd3;

  localparam logic [9:0] SymCtrl00 = 10'b1101010100;
  localparam logic [9:0] SymCtrl01 = 10'b0010101011;
  localparam logic [9:0] SymCtrl10 = 10'b0101010100;
  localparam logic [9:0] SymCtrl11 = 10'b1010101011;
  localparam logic [9:0] SymGuard  = (ChannelIndex == 1) ? 10'b0100110011 : 10'b1011001100;

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm;

  logic [8:0] s1_qm;
  logic [2:0] s1_period;
  logic [1:0] s1_ctrl;

  logic [3:0]        n1;
  logic [3:0]        n0;
  logic signed [5:0] diff;
  logic signed [5:0] cnt;
  logic signed [5:0] cnt_nxt;
  logic [9:0]        sym_nxt;
  logic [9:0]        s2_tmds;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, data[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    qm = '0;
    qm[0] = data[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
    qm[8] = ~use_xnor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_qm     <= '0;
      s1_period <= PeriodControl;
      s1_ctrl   <= '0;
    end else begin
      s1_qm     <= qm;
      s1_period <= period;
      s1_ctrl   <= ctrl;
    end
  end

  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, s1_qm[i]};
    n0      = 4'd8 - n1;
    diff    = signed'({2'b00, n1}) - signed'({2'b00, n0});
    sym_nxt = SymCtrl00;
    cnt_nxt = '0;
    case (s1_period)
      PeriodVideoGuard: sym_nxt = SymGuard;
      PeriodVideoData: begin
        if ((cnt == 6'sd0) || (n1 == n0)) begin
          sym_nxt = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
          cnt_nxt = s1_qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (n1 > n0)) || ((cnt < 6'sd0) && (n0 > n1))) begin
          sym_nxt = {1'b1, s1_qm[8], ~s1_qm[7:0]};
          cnt_nxt = cnt + signed'({4'b0000, s1_qm[8], 1'b0}) - diff;
        end else begin
          sym_nxt = {1'b0, s1_qm[8], s1_qm[7:0]};
          cnt_nxt = cnt + diff - signed'({4'b0000, ~s1_qm[8], 1'b0});
        end
      end
      default: begin
        // Preamble and data-island periods also send control symbols.
        case (s1_ctrl)
          2'b00:   sym_nxt = SymCtrl00;
          2'b01:   sym_nxt = SymCtrl01;
          2'b10:   sym_nxt = SymCtrl10;
          default: sym_nxt = SymCtrl11;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      s2_tmds <= SymCtrl00;
    end else begin
      cnt     <= cnt_nxt;
      s2_tmds <= sym_nxt;
    end
  end

`ifdef H14TX_TMDS_OUT_REG_EN
  logic [9:0] s3_tmds;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3_tmds <= SymCtrl00;
    else        s3_tmds <= s2_tmds;
  end

  assign tmds = s3_tmds;
`else
  assign tmds = s2_tmds;
`endif

endmodule

// File: tb/tb_h14tx_tmds_channel.sv
// Scoreboard bench for h14tx_tmds_channel: channel 0 and channel 1 instances fed the same stream.
module tb_h14tx_tmds_channel;

`ifdef H14TX_TMDS_OUT_REG_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  localparam logic [2:0] P_CTRL  = 3'd0;
  localparam logic [2:0] P_PRE   = 3'd1;
  localparam logic [2:0] P_GUARD = 3'd2;
  localparam logic [2:0] P_DATA  = 3'd3;

  typedef struct {
    logic [9:0] s0;
    logic [9:0] s1;
    logic       is_data;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] period = P_CTRL;
  logic [7:0] data = 8'h00;
  logic [1:0] ctrl = 2'b00;
  logic [9:0] tmds0;
  logic [9:0] tmds1;

  exp_t  exp_q[$];
  string tag_q[$];
  int    m_cnt = 0;
  int    disp = 0;
  int    max_abs = 0;
  int    errors = 0;
  int    checks = 0;

  h14tx_tmds_channel #(.ChannelIndex(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .period(period), .data(data), .ctrl(ctrl), .tmds(tmds0)
  );
  h14tx_tmds_channel #(.ChannelIndex(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .period(period), .data(data), .ctrl(ctrl), .tmds(tmds1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // Reference encoder written from the DVI algorithm with integer disparity.
  task automatic model_step(input logic [2:0] p, input logic [7:0] d, input logic [1:0] c,
                            output exp_t e);
    int ones, n1, n0;
    logic xn;
    logic [8:0] q;
    logic [9:0] s;
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    e.is_data = 1'b0;
    e.d = d;
    if (p == P_DATA) begin
      e.is_data = 1'b1;
      if (m_cnt == 0 || n1 == n0) begin
        s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        m_cnt += q[8] ? (n1 - n0) : (n0 - n1);
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        s = {1'b1, q[8], ~q[7:0]};
        m_cnt += (q[8] ? 2 : 0) + n0 - n1;
      end else begin
        s = {1'b0, q[8], q[7:0]};
        m_cnt += n1 - n0 - (q[8] ? 0 : 2);
      end
      e.s0 = s;
      e.s1 = s;
    end else if (p == P_GUARD) begin
      e.s0 = 10'b1011001100;
      e.s1 = 10'b0100110011;
      m_cnt = 0;
    end else begin
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      e.s0 = s;
      e.s1 = s;
      m_cnt = 0;
    end
  endtask

  task automatic prime(input string tag);
    exp_t e;
    exp_q.delete();
    tag_q.delete();
    m_cnt = 0;
    disp = 0;
    e.s0 = 10'h354;
    e.s1 = 10'h354;
    e.is_data = 1'b0;
    e.d = 8'h00;
    for (int i = 0; i < Lat; i++) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic step(input logic [2:0] p, input logic [7:0] d, input logic [1:0] c,
                      input string tag);
    exp_t e;
    string t;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, "_ch0"}, tmds0, e.s0);
    check_val({t, "_ch1"}, tmds1, e.s1);
    if (e.is_data) begin
      check_val({t, "_dec"}, {2'b00, decode(tmds1)}, {2'b00, e.d});
      disp += 2 * $countones(tmds1) - 10;
      if (disp > max_abs) max_abs = disp;
      if (-disp > max_abs) max_abs = -disp;
    end else begin
      disp = 0;
    end
    period = p;
    data = d;
    ctrl = c;
    model_step(p, d, c, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic flush();
    for (int i = 0; i < Lat; i++) step(P_CTRL, 8'h00, 2'b00, "flush");
  endtask

  initial begin
    // Reset held with non-control inputs must still show control-00.
    period = P_DATA;
    data = 8'hA5;
    ctrl = 2'b11;
    #2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("reset_ch0", tmds0, 10'h354);
      check_val("reset_ch1", tmds1, 10'h354);
    end
    period = P_CTRL;
    ctrl = 2'b00;
    rst_n = 1'b1;
    prime("post_reset");

    step(P_CTRL, 8'h00, 2'b00, "ctl00");
    step(P_CTRL, 8'h00, 2'b01, "ctl01");
    step(P_CTRL, 8'h00, 2'b10, "ctl10");
    step(P_CTRL, 8'h00, 2'b11, "ctl11");
    step(P_PRE,  8'h00, 2'b01, "preamble");
    step(P_GUARD, 8'h00, 2'b00, "guard");
    step(P_GUARD, 8'h00, 2'b00, "guard2");

    step(P_CTRL, 8'h00, 2'b00, "ctl");
    step(P_DATA, 8'h00, 2'b00, "disp0");
    step(P_DATA, 8'h00, 2'b00, "disp1");
    step(P_DATA, 8'h00, 2'b00, "disp2");

    step(P_CTRL, 8'h00, 2'b00, "ctl");
    step(P_DATA, 8'hFF, 2'b00, "xnor");
    step(P_CTRL, 8'h00, 2'b00, "ctl_after");
    step(P_DATA, 8'h55, 2'b00, "branch_a");
    step(P_DATA, 8'h10, 2'b00, "data_b");
    flush();

    max_abs = 0;
    for (int i = 0; i < 10000; i++) step(P_DATA, 8'($urandom), 2'b00, "rand");
    flush();
    check_val("disp_bound", {9'b0, (max_abs > 10)}, 10'd0);

    for (int i = 0; i < 500; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), 2'($urandom), "mixed");
    flush();

    for (int i = 0; i < 20; i++) step(P_DATA, 8'($urandom), 2'b00, "pre_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_ch0", tmds0, 10'h354);
    check_val("async_rst_ch1", tmds1, 10'h354);
    @(negedge clk);
    period = P_CTRL;
    data = 8'h00;
    ctrl = 2'b00;
    rst_n = 1'b1;
    prime("post_rst");
    step(P_DATA, 8'h3C, 2'b00, "first_after_rst");
    step(P_DATA, 8'hC3, 2'b00, "second_after_rst");
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
